multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXECUTE/MEM/WB sequencing over one shared memory port.
// An unsupported instruction parks the core in HALT until the next reset.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halt,
  output logic [31:0]           instret
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb,
    StHalt
  } state_e;

  state_e      state_q;
  logic [31:0] ir_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_out_q;
  logic [31:0] mdr_q;
  logic [31:0] regs_q [32];

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [31:0]           imm_sext;
  logic [31:0]           branch_off;
  logic [31:0]           alu_res;
  logic                  op_valid;
  logic [27:0]           jump_low;
  logic [ADDR_WIDTH-1:0] jump_pc;
  logic [ADDR_WIDTH-1:0] branch_pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] exec_pc;
  logic [4:0]            wb_dest;
  logic [31:0]           wb_data;

  assign opcode     = ir_q[31:26];
  assign funct      = ir_q[5:0];
  assign imm_sext   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign jump_low   = {ir_q[25:0], 2'b00};
  assign pc_inc     = pc + ADDR_WIDTH'(4);
  // pc already points past the branch here, so the offset is relative to pc+4
  assign branch_pc  = pc + branch_off[ADDR_WIDTH-1:0];

  if (ADDR_WIDTH > 28) begin : g_jump_hi
    assign jump_pc = {pc[ADDR_WIDTH-1:28], jump_low};
  end else begin : g_jump_lo
    assign jump_pc = jump_low[ADDR_WIDTH-1:0];
  end

  always_comb begin
    if (opcode == OpJ) begin
      exec_pc = jump_pc;
    end else if (a_q == b_q) begin
      exec_pc = branch_pc;
    end else begin
      exec_pc = pc;
    end
  end

  always_comb begin
    alu_res  = a_q + imm_sext;
    op_valid = 1'b1;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAdd:   alu_res = a_q + b_q;
          FnSub:   alu_res = a_q - b_q;
          FnAnd:   alu_res = a_q & b_q;
          FnOr:    alu_res = a_q | b_q;
          FnSlt:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
          default: op_valid = 1'b0;
        endcase
      end
      OpAddi, OpLw, OpSw, OpBeq, OpJ: op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  end

  assign wb_dest = (opcode == OpRtype) ? ir_q[15:11] : ir_q[20:16];
  assign wb_data = (opcode == OpLw) ? mdr_q : alu_out_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      pc        <= RESET_PC[ADDR_WIDTH-1:0];
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halt      <= 1'b0;
      instret   <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StFetch: begin
          // Only reached with mem_req low right after reset; later entries pre-arm the request
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir_q    <= mem_rdata;
            pc      <= pc_inc;
            mem_req <= 1'b0;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          a_q     <= regs_q[ir_q[25:21]];
          b_q     <= regs_q[ir_q[20:16]];
          state_q <= StExecute;
        end
        StExecute: begin
          if (!op_valid) begin
            halt    <= 1'b1;
            state_q <= StHalt;
          end else begin
            alu_out_q <= alu_res;
            case (opcode)
              OpLw, OpSw: begin
                mem_req   <= 1'b1;
                mem_we    <= (opcode == OpSw);
                mem_addr  <= alu_res[ADDR_WIDTH-1:0];
                mem_wdata <= (opcode == OpSw) ? b_q : '0;
                state_q   <= StMem;
              end
              OpBeq, OpJ: begin
                pc       <= exec_pc;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= exec_pc;
                instret  <= instret + 32'd1;
                state_q  <= StFetch;
              end
              default: state_q <= StWb;
            endcase
          end
        end
        StMem: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            if (opcode == OpLw) begin
              mdr_q   <= mem_rdata;
              mem_req <= 1'b0;
              state_q <= StWb;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= pc;
              instret  <= instret + 32'd1;
              state_q  <= StFetch;
            end
          end
        end
        StWb: begin
          if (wb_dest != 5'd0) begin
            regs_q[wb_dest] <= wb_data;
          end
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
          instret  <= instret + 32'd1;
          state_q  <= StFetch;
        end
        StHalt: begin
          halt    <= 1'b1;
          mem_req <= 1'b0;
        end
        default: state_q <= StHalt;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: word-addressed memory model with programmable ack
// latency, hand-encoded programs and hand-computed register/pc/instret expectations.
module tb_multicycle_datapath;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack;
  logic [31:0] pc;
  logic        halt;
  logic [31:0] instret;

  logic        ack_model = 1'b0;
  logic        ack_stray = 1'b0;
  logic [31:0] mem [64];
  int          lat = 1;
  int          wait_cnt = 0;
  int          we_cycles = 0;
  int          rd_cycles = 0;
  int          drop_count = 0;
  int          wr_count = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  int errors = 0;
  int checks = 0;

  assign mem_ack = ack_model | ack_stray;

  always #5 clock = ~clock;

  multicycle_datapath #(
    .RESET_PC  (32'h0000_0000),
    .ADDR_WIDTH(32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .pc       (pc),
    .halt     (halt),
    .instret  (instret)
  );

  // Memory responds on the falling edge so the DUT samples a stable ack on the next rising edge.
  always @(negedge clock) begin
    if (mem_req && reset) begin
      if (mem_we) we_cycles = we_cycles + 1;
      else rd_cycles = rd_cycles + 1;
      wait_cnt = wait_cnt + 1;
      if (wait_cnt >= lat) begin
        ack_model = 1'b1;
        wait_cnt  = 0;
        if (mem_we) begin
          mem[mem_addr[7:2]] = mem_wdata;
          wr_count = wr_count + 1;
          wr_addr  = mem_addr;
          wr_data  = mem_wdata;
        end else begin
          mem_rdata = mem[mem_addr[7:2]];
        end
      end else begin
        ack_model = 1'b0;
      end
    end else begin
      if (wait_cnt != 0 && reset) drop_count = drop_count + 1;
      ack_model = 1'b0;
      wait_cnt  = 0;
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] idx);
    return {6'h02, idx};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic begin_test(input int latency);
    @(negedge clock);
    reset     = 1'b0;
    ack_stray = 1'b0;
    lat       = latency;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset      = 1'b1;
    we_cycles  = 0;
    rd_cycles  = 0;
    drop_count = 0;
    wr_count   = 0;
  endtask

  task automatic wait_halt(input int max_cycles);
    int n = 0;
    while (!halt && n < max_cycles) begin
      step(1);
      n++;
    end
    check("halt_reached", {31'b0, halt}, 32'd1);
  endtask

  initial begin
    // ALU program, zero-wait memory
    begin_test(1);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_instret", instret, 32'd0);
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
    mem[4] = enc_r(5'd1, 5'd2, 5'd5, 6'h22);
    mem[5] = enc_r(5'd1, 5'd2, 5'd6, 6'h24);
    mem[6] = enc_r(5'd1, 5'd2, 5'd7, 6'h25);
    mem[7] = enc_r(5'd1, 5'd2, 5'd8, 6'h2A);
    release_reset();
    step(1);
    check("first_fetch_req", {31'b0, mem_req}, 32'd1);
    check("first_fetch_addr", mem_addr, 32'd0);
    step(15);
    check("alu_instret_at16", instret, 32'd3);
    step(1);
    check("alu_instret_at17", instret, 32'd4);
    check("alu_r2", dut.regs_q[2], 32'hFFFF_FFFD);
    check("alu_r3_add", dut.regs_q[3], 32'd2);
    check("alu_r4_slt", dut.regs_q[4], 32'd1);
    step(16);
    check("alu_instret_8", instret, 32'd8);
    check("alu_r5_sub", dut.regs_q[5], 32'd8);
    check("alu_r6_and", dut.regs_q[6], 32'd5);
    check("alu_r7_or", dut.regs_q[7], 32'hFFFF_FFFD);
    check("alu_r8_slt_signed", dut.regs_q[8], 32'd0);
    wait_halt(20);
    check("alu_instret_final", instret, 32'd8);

    // sw/lw through a 3-cycle memory, program placed at 0x40 via j
    begin_test(3);
    mem[0]  = enc_j(26'h10);
    mem[16] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[17] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    mem[18] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
    release_reset();
    wait_halt(200);
    check("ls_instret", instret, 32'd4);
    check("ls_r5", dut.regs_q[5], 32'd5);
    check("ls_mem_word", mem[2], 32'd5);
    check("ls_wr_count", wr_count, 32'd1);
    check("ls_wr_addr", wr_addr, 32'd8);
    check("ls_wr_data", wr_data, 32'd5);
    check("ls_we_cycles", we_cycles, 32'd3);
    check("ls_rd_cycles", rd_cycles, 32'd18);
    check("ls_req_drops", drop_count, 32'd0);
    check("ls_halt_pc", pc, 32'h50);

    // beq $0,$0,-1 loop at 0x10
    begin_test(1);
    mem[0] = enc_j(26'h4);
    mem[4] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    release_reset();
    step(7);
    check("beq_pc_loop1", pc, 32'h10);
    check("beq_instret_loop1", instret, 32'd2);
    step(1);
    check("beq_pc_mid", pc, 32'h14);
    step(2);
    check("beq_pc_loop2", pc, 32'h10);
    check("beq_instret_loop2", instret, 32'd3);
    step(3);
    check("beq_pc_loop3", pc, 32'h10);
    check("beq_instret_loop3", instret, 32'd4);
    check("beq_no_halt", {31'b0, halt}, 32'd0);

    // write to $0 is discarded
    begin_test(1);
    mem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    release_reset();
    step(5);
    check("r0_instret", instret, 32'd1);
    check("r0_zero", dut.regs_q[0], 32'd0);
    wait_halt(20);
    check("r0_instret_final", instret, 32'd1);

    // unsupported opcode 0x3F
    begin_test(1);
    mem[0] = {6'h3F, 26'h0};
    release_reset();
    step(3);
    check("bad_op_not_yet", {31'b0, halt}, 32'd0);
    step(1);
    check("bad_op_halt", {31'b0, halt}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("bad_op_pc_frozen", pc, 32'd4);
      check("bad_op_req_low", {31'b0, mem_req}, 32'd0);
      check("bad_op_halt_held", {31'b0, halt}, 32'd1);
    end
    check("bad_op_instret", instret, 32'd0);

    // reset during a MEM wait, then a stray ack
    begin_test(6);
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'd0);
    release_reset();
    begin
      int n = 0;
      while (!(instret == 32'd1 && mem_req && mem_addr == 32'd0) && n < 200) begin
        step(1);
        n++;
      end
      check("mem_wait_reached", {31'b0, (n < 200)}, 32'd1);
    end
    check("pre_reset_r1", dut.regs_q[1], 32'd5);
    step(2);
    reset = 1'b0;
    #1;
    check("midrst_req", {31'b0, mem_req}, 32'd0);
    check("midrst_pc", pc, 32'd0);
    check("midrst_instret", instret, 32'd0);
    check("midrst_r1", dut.regs_q[1], 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'd0);
    @(negedge clock);
    @(negedge clock);
    #1;
    reset     = 1'b1;
    ack_stray = 1'b1;
    @(posedge clock);
    #1;
    ack_stray = 1'b0;
    check("stray_state", 32'(dut.state_q), 32'd0);
    check("stray_pc", pc, 32'd0);
    check("stray_ir", dut.ir_q, 32'd0);
    check("stray_req", {31'b0, mem_req}, 32'd1);
    check("stray_addr", mem_addr, 32'd0);
    check("stray_instret", instret, 32'd0);
    check("stray_r2", dut.regs_q[2], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
